// File: rtl/uart_rx_core.sv
// Receive half of the memory-mapped UART: recovers 8N1 frames from rx_serial
// and holds one byte with valid/error status until the bus acknowledges it.
module uart_rx_core #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DIVISOR = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [13:0]          baud_divisor,
    input  logic                 rx_serial,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [13:0]            div_l;
    logic [13:0]            div_clamped;
    logic [13:0]            limit;
    logic [13:0]            baud_cnt;
    logic                   counting;
    logic                   tick;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;

    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
    end

    assign rxs         = sync_q[SYNC_STAGES-1];
    assign div_clamped = (baud_divisor < 14'(MIN_DIVISOR)) ? 14'(MIN_DIVISOR) : baud_divisor;
    assign limit       = (state == START) ? {1'b0, div_l[13:1]} : div_l;
    assign counting    = (state == START) || (state == DATA) || (state == STOP);
    assign tick        = counting && (baud_cnt == limit - 14'd1);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves state_next unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rxs) state_next = START;
            START: if (tick) state_next = rxs ? IDLE : DATA;
            DATA:  if (tick && bit_cnt == BIT_W'(DATA_BITS - 1)) state_next = STOP;
            STOP:  if (tick) state_next = rxs ? IDLE : BREAK;
            BREAK: if (rxs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Baud counter restarts on every state change so each phase times from its entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            div_l    <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            if (!counting || tick || state_next != state) baud_cnt <= '0;
            else                                          baud_cnt <= baud_cnt + 14'd1;

            if (state == IDLE && state_next == START) div_l <= div_clamped;

            if (state != DATA) bit_cnt <= '0;
            else if (tick)     bit_cnt <= bit_cnt + 1'b1;

            if (state == DATA && tick) shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
        end
    end

    // A STOP tick takes priority over a coincident rd_ack: the new byte wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (state == STOP && tick) begin
            rx_data   <= shift_q;
            rx_valid  <= 1'b1;
            frame_err <= ~rxs;
            overrun   <= rx_valid & ~rd_ack;
        end else if (rd_ack && rx_valid) begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Receive half of the memory-mapped UART; the counterpart of the transmit path.
- Recovers 8N1 frames from the asynchronous rx_serial line.
- Uses the same 14-bit baud divisor (clocks per bit) that software programs for transmit.
- Holds one received byte with valid/error status for the bus read logic, which acknowledges with rd_ack.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first, no parity
SYNC_STAGES, 2, flops in rx_serial synchronizer (>=2)
MIN_DIVISOR, 4, smallest divisor honoured; smaller values clamp to this

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
baud_divisor  input  14  clocks per bit time (868 = 115200 baud at 100 MHz)
rx_serial  input  1  raw serial line, idle high
rd_ack  input  1  one-cycle pulse: bus has consumed rx_data/status
rx_data  output  DATA_BITS  last received byte
rx_valid  output  1  rx_data holds an unread byte
frame_err  output  1  stop bit of the byte in rx_data sampled low
overrun  output  1  new byte overwrote an unread byte
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high) puts every output and register in a known state:
  - Synchronizer flops = 1.
  - rx_data = 0; rx_valid, frame_err, overrun, busy = 0.
  - State = IDLE; bit counter and baud counter = 0.
- rx_serial passes through SYNC_STAGES flops; all decisions use the synchronized value rxs.
- Divisor latch: on leaving IDLE, div_l = max(baud_divisor, MIN_DIVISOR). div_l stays fixed for the whole frame, so mid-frame writes to baud_divisor have no effect until the next frame.
- Baud counter: 14-bit, counts 0..limit-1, then zeroes and raises a one-cycle sample tick. It restarts from 0 on every state entry.
- IDLE:
  - rxs==0 -> START, counter limit = div_l>>1.
- START:
  - On tick, rxs==0 -> DATA (bit count 0, limit = div_l).
  - On tick, rxs==1 -> IDLE (glitch rejected, no status change).
- DATA:
  - Each tick shifts rxs into the MSB of the shift register (LSB-first line order).
  - After DATA_BITS ticks -> STOP.
- STOP:
  - On tick, rx_data <= shift register and rx_valid <= 1, registered at that same edge.
  - frame_err <= ~rxs.
  - overrun <= 1 if rx_valid was already 1 and rd_ack is not asserted that cycle; otherwise 0.
  - Next state: rxs==1 -> IDLE; rxs==0 -> BREAK.
- BREAK: wait for rxs==1, then -> IDLE. A held-low line therefore yields exactly one frame.
- Timing: the start-bit midpoint falls div_l>>1 clocks after the start is detected. Each following sample is div_l clocks later. Total frame = (div_l>>1) + (DATA_BITS+1)*div_l clocks after detection.
- rd_ack:
  - Clears rx_valid, frame_err and overrun on the next edge.
  - rd_ack in the same cycle as a STOP tick: the new byte wins. rx_valid stays 1, frame_err reflects the new frame, overrun = 0.
  - rd_ack while rx_valid==0 has no effect.
- busy is combinational from state (!= IDLE).
- Reset asserted mid-frame aborts immediately; no partial byte is written.

Test Plan:
1. div=868, send 0xA5 8N1 -> rx_valid=1, rx_data=0xA5, frame_err=0, overrun=0. First data sample 434+868 clocks after detection. rd_ack clears rx_valid.
2. rx_serial low for 100 clocks, then high (div=868) -> returns to IDLE at the START tick; rx_valid stays 0, busy low again.
3. Send 0x3C with stop bit low, line released one bit later -> rx_data=0x3C, rx_valid=1, frame_err=1. FSM passes through BREAK; no second frame.
4. Send 0x11 then 0x22 with no rd_ack -> rx_data=0x22, overrun=1. Repeat with rd_ack coincident with the 0x22 STOP tick -> rx_valid=1, overrun=0.
5. Write baud_divisor 868->434 during a frame of 0x5A -> frame still decodes 0x5A at 868. The next frame, sent at 434, decodes correctly.
6. Assert reset mid-DATA, release, send 0xFF with div=2 (clamped to 4) -> all outputs 0 after reset; 0xFF then received with frame_err=0.
